// File: rtl/ibex_ahb_pkg.sv
// Shared AHB-Lite encodings and the address/data-phase owner type for the
// ibex instruction/data bus arbiter.
package ibex_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [3:0] HPROT_INSTR = 4'b0010;
  localparam logic [3:0] HPROT_DATA  = 4'b0011;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

endpackage

// File: rtl/ibex_ahb_be2size.sv
// Maps ibex data byte enables onto an AHB transfer size and the low address
// bits. Any pattern that is not a naturally aligned byte, half or word is
// flagged illegal and never reaches the bus.
module ibex_ahb_be2size
  import ibex_ahb_pkg::*;
(
  input  logic [3:0] data_be,
  output logic [2:0] hsize,
  output logic [1:0] addr_off,
  output logic       illegal
);

  // Pure decode of the byte-enable pattern
  always_comb begin
    hsize    = HSIZE_WORD;
    addr_off = 2'd0;
    illegal  = 1'b0;
    case (data_be)
      4'b0001: begin hsize = HSIZE_BYTE; addr_off = 2'd0; end
      4'b0010: begin hsize = HSIZE_BYTE; addr_off = 2'd1; end
      4'b0100: begin hsize = HSIZE_BYTE; addr_off = 2'd2; end
      4'b1000: begin hsize = HSIZE_BYTE; addr_off = 2'd3; end
      4'b0011: begin hsize = HSIZE_HALF; addr_off = 2'd0; end
      4'b1100: begin hsize = HSIZE_HALF; addr_off = 2'd2; end
      4'b1111: begin hsize = HSIZE_WORD; addr_off = 2'd0; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ibex_ahb_arbiter.sv
// Shares one AHB-Lite master port between the ibex instruction and data
// ports. Address phase is driven combinationally by the arbitration winner;
// the data phase is tracked in registers so the next address phase can
// overlap it.
//
//   state          | meaning
//   ---------------+------------------------------------------------------
//   aph_lock       | winner saw HREADY=0; owner held until its grant
//   dph_valid      | a bus transfer is in its data phase for dph_owner
//   ill_pend       | illegal-BE data request granted; error response due
//   run_cnt        | data grants in a row while a fetch has been waiting
module ibex_ahb_arbiter
  import ibex_ahb_pkg::*;
#(
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic        instr_err_o,
  output logic [31:0] instr_rdata_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  output logic [31:0] data_rdata_o,

  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam int CW = $clog2(MAX_DATA_RUN + 1);

  logic          aph_lock;
  owner_e        aph_owner;
  logic          dph_valid;
  owner_e        dph_owner;
  logic          ill_pend;
  logic [CW-1:0] run_cnt;

  logic [2:0] be_hsize;
  logic [1:0] be_off;
  logic       be_illegal;
  logic       run_max, err_first;
  logic       instr_sel, data_sel, data_bus;
  logic       dph_done, data_resp, ill_resp;
  logic       unused_addr_lsb;

  ibex_ahb_be2size u_be2size (
    .data_be  (data_be_i),
    .hsize    (be_hsize),
    .addr_off (be_off),
    .illegal  (be_illegal)
  );

  // Word address comes from the core; the byte offset is rebuilt from BE
  assign unused_addr_lsb = ^data_addr_i[1:0];

  assign run_max   = (run_cnt == CW'(MAX_DATA_RUN));
  assign err_first = HRESP & ~HREADY;

  // Pick the address-phase owner: a locked owner keeps the slot, otherwise
  // data wins unless the fetch has been starved for a full run
  always_comb begin
    instr_sel = 1'b0;
    data_sel  = 1'b0;
    if (!HRESET && !err_first) begin
      if (aph_lock) begin
        if (aph_owner == OWN_DATA) data_sel  = data_req_i;
        else                       instr_sel = instr_req_i;
      end else if (data_req_i && !(run_max && instr_req_i)) begin
        data_sel = 1'b1;
      end else if (instr_req_i) begin
        instr_sel = 1'b1;
      end
    end
  end

  assign instr_gnt_o = instr_sel & HREADY;
  assign data_gnt_o  = data_sel & HREADY;
  assign data_bus    = data_sel & ~be_illegal;

  // Drive the address phase for the winner; illegal BE never reaches the bus
  always_comb begin
    HTRANS = HTRANS_IDLE;
    HADDR  = 32'd0;
    HSIZE  = HSIZE_BYTE;
    HWRITE = 1'b0;
    HPROT  = HPROT_INSTR;
    if (instr_sel) begin
      HTRANS = HTRANS_NONSEQ;
      HADDR  = instr_addr_i;
      HSIZE  = HSIZE_WORD;
    end else if (data_bus) begin
      HTRANS = HTRANS_NONSEQ;
      HADDR  = {data_addr_i[31:2], be_off};
      HSIZE  = be_hsize;
      HWRITE = data_we_i;
      HPROT  = HPROT_DATA;
    end
  end

  assign dph_done  = dph_valid & HREADY & ~HRESET;
  assign data_resp = dph_done & (dph_owner == OWN_DATA);
  assign ill_resp  = ill_pend & ~HRESET;

  assign instr_rvalid_o = dph_done & (dph_owner == OWN_INSTR);
  assign instr_err_o    = instr_rvalid_o & HRESP;
  assign instr_rdata_o  = HRDATA;
  assign data_rvalid_o  = data_resp | ill_resp;
  assign data_err_o     = (data_resp & HRESP) | ill_resp;
  assign data_rdata_o   = HRDATA;

  // Hold the address-phase owner across wait states; an error cancels it
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      aph_lock  <= 1'b0;
      aph_owner <= OWN_INSTR;
    end else if (err_first || instr_gnt_o || data_gnt_o) begin
      aph_lock  <= 1'b0;
    end else if (instr_sel || data_sel) begin
      aph_lock  <= 1'b1;
      aph_owner <= data_sel ? OWN_DATA : OWN_INSTR;
    end
  end

  // Track the data phase and capture store data at grant
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dph_valid <= 1'b0;
      dph_owner <= OWN_INSTR;
      HWDATA    <= 32'd0;
      ill_pend  <= 1'b0;
    end else begin
      if (instr_gnt_o || (data_gnt_o && !be_illegal)) begin
        dph_valid <= 1'b1;
        dph_owner <= instr_gnt_o ? OWN_INSTR : OWN_DATA;
      end else if (HREADY) begin
        dph_valid <= 1'b0;
      end
      if (data_gnt_o && !be_illegal && data_we_i) HWDATA <= data_wdata_i;
      ill_pend <= data_gnt_o & be_illegal;
    end
  end

  // Count data grants that overtake a waiting fetch, saturating at the limit
  always_ff @(posedge HCLK) begin
    if (HRESET || !instr_req_i || instr_gnt_o) begin
      run_cnt <= '0;
    end else if (data_gnt_o && !run_max) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ibex_ahb_arbiter.sv
// Directed bench for ibex_ahb_arbiter: inputs change just after the falling
// edge, outputs are compared 1ns later, well clear of the rising edge.
module tb_ibex_ahb_arbiter;
  import ibex_ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE, HREADY, HRESP;
  logic [3:0]  HPROT;

  int checks = 0;
  int errors = 0;

  logic [3:0] be_tab   [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h0};
  logic [2:0] size_tab [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd0};
  logic [1:0] off_tab  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0, 2'd0};

  ibex_ahb_arbiter #(.MAX_DATA_RUN(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_err_o(instr_err_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_err_o(data_err_o), .data_rdata_o(data_rdata_o),
    .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(negedge HCLK);
  endtask

  task automatic test_reset();
    HRESET = 1'b1; instr_req_i = 1'b1; instr_addr_i = 32'h0000_0040;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'hF;
    data_addr_i = 32'd0; data_wdata_i = 32'd0;
    HRDATA = 32'd0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (2) @(posedge HCLK);
    tick(); #1;
    checks++;
    if ({HTRANS, HADDR, HSIZE, HWRITE, HWDATA, HPROT} !== {2'b00, 32'd0, 3'd0, 1'b0, 32'd0, 4'b0010}) begin
      errors++; $display("FAIL reset_bus got %h %h %h %b %h %h", HTRANS, HADDR, HSIZE, HWRITE, HWDATA, HPROT);
    end
    checks++;
    if ({instr_gnt_o, instr_rvalid_o, instr_err_o, data_gnt_o, data_rvalid_o, data_err_o} !== 6'b0) begin
      errors++; $display("FAIL reset_hs got %b%b%b %b%b%b exp all 0", instr_gnt_o, instr_rvalid_o,
                         instr_err_o, data_gnt_o, data_rvalid_o, data_err_o);
    end
    tick(); HRESET = 1'b0; instr_req_i = 1'b0;
  endtask

  task automatic test_instr_stream();
    for (int i = 0; i < 4; i++) begin
      tick();
      instr_req_i  = (i < 3);
      instr_addr_i = 32'h100 + 32'(4 * i);
      HRDATA       = 32'h1111_0000 + 32'(i);
      #1;
      checks++;
      if ({instr_gnt_o, HTRANS} !== {(i < 3), ((i < 3) ? 2'b10 : 2'b00)}) begin
        errors++; $display("FAIL instr_gnt[%0d] got gnt=%b htrans=%b", i, instr_gnt_o, HTRANS);
      end
      if (i < 3) begin
        checks++;
        if ({HADDR, HSIZE, HPROT, HWRITE} !== {32'h100 + 32'(4 * i), 3'd2, 4'b0010, 1'b0}) begin
          errors++; $display("FAIL instr_addr[%0d] got %h %h %h %b", i, HADDR, HSIZE, HPROT, HWRITE);
        end
      end
      checks++;
      if ({instr_rvalid_o, instr_rdata_o} !== {(i > 0), 32'h1111_0000 + 32'(i)}) begin
        errors++; $display("FAIL instr_rvalid[%0d] got %b %h", i, instr_rvalid_o, instr_rdata_o);
      end
    end
    tick(); #1;
    checks++;
    if (instr_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL instr_rvalid_end got %b exp 0", instr_rvalid_o);
    end
  endtask

  task automatic test_fairness();
    tick();
    instr_req_i = 1'b1; instr_addr_i = 32'h400;
    data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h2000;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      #1;
      checks++;
      if (i == 4) begin
        if ({instr_gnt_o, data_gnt_o, HADDR, HPROT} !== {2'b10, 32'h400, 4'b0010}) begin
          errors++; $display("FAIL fair_instr[%0d] got ig=%b dg=%b %h %h", i, instr_gnt_o, data_gnt_o, HADDR, HPROT);
        end
      end else begin
        if ({instr_gnt_o, data_gnt_o, HADDR, HPROT, HSIZE} !== {2'b01, 32'h2000, 4'b0011, 3'd2}) begin
          errors++; $display("FAIL fair_data[%0d] got ig=%b dg=%b %h %h", i, instr_gnt_o, data_gnt_o, HADDR, HPROT);
        end
      end
      checks++;
      if ({instr_rvalid_o, data_rvalid_o} !== {(i == 5), (i > 0 && i != 5)}) begin
        errors++; $display("FAIL fair_rvalid[%0d] got i=%b d=%b", i, instr_rvalid_o, data_rvalid_o);
      end
    end
    tick(); instr_req_i = 1'b0; data_req_i = 1'b0; #1;
    checks++;
    if ({data_rvalid_o, HTRANS} !== {1'b1, 2'b00}) begin
      errors++; $display("FAIL fair_tail got rv=%b htrans=%b", data_rvalid_o, HTRANS);
    end
  endtask

  task automatic test_store_wait();
    tick();
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0010;
    data_addr_i = 32'h3001; data_wdata_i = 32'hAABB_CCDD; #1;
    checks++;
    if ({data_gnt_o, HTRANS, HADDR, HSIZE, HWRITE} !== {1'b1, 2'b10, 32'h3001, 3'd0, 1'b1}) begin
      errors++; $display("FAIL store_aph got %b %b %h %h %b", data_gnt_o, HTRANS, HADDR, HSIZE, HWRITE);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      data_req_i = 1'b0; data_we_i = 1'b0; data_wdata_i = 32'd0;
      HREADY = (i == 3); #1;
      checks++;
      if ({HWDATA, data_rvalid_o, data_err_o} !== {32'hAABB_CCDD, (i == 3), 1'b0}) begin
        errors++; $display("FAIL store_dph[%0d] got %h rv=%b err=%b", i, HWDATA, data_rvalid_o, data_err_o);
      end
    end
    tick(); #1;
    checks++;
    if (data_rvalid_o !== 1'b0) begin
      errors++; $display("FAIL store_done got %b exp 0", data_rvalid_o);
    end
  endtask

  task automatic test_aph_lock();
    tick(); instr_req_i = 1'b1; instr_addr_i = 32'h500; HREADY = 1'b0; #1;
    checks++;
    if ({instr_gnt_o, HTRANS, HADDR} !== {1'b0, 2'b10, 32'h500}) begin
      errors++; $display("FAIL lock_start got %b %b %h", instr_gnt_o, HTRANS, HADDR);
    end
    tick(); data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h6000; #1;
    checks++;
    if ({instr_gnt_o, data_gnt_o, HADDR, HPROT} !== {2'b00, 32'h500, 4'b0010}) begin
      errors++; $display("FAIL lock_hold got %b %b %h %h", instr_gnt_o, data_gnt_o, HADDR, HPROT);
    end
    tick(); HREADY = 1'b1; #1;
    checks++;
    if ({instr_gnt_o, data_gnt_o, HADDR} !== {2'b10, 32'h500}) begin
      errors++; $display("FAIL lock_release got %b %b %h", instr_gnt_o, data_gnt_o, HADDR);
    end
    tick(); instr_req_i = 1'b0; #1;
    checks++;
    if ({data_gnt_o, HADDR, instr_rvalid_o} !== {1'b1, 32'h6000, 1'b1}) begin
      errors++; $display("FAIL lock_next got %b %h irv=%b", data_gnt_o, HADDR, instr_rvalid_o);
    end
    tick(); data_req_i = 1'b0; #1;
    checks++;
    if (data_rvalid_o !== 1'b1) begin
      errors++; $display("FAIL lock_drv got %b exp 1", data_rvalid_o);
    end
  endtask

  task automatic test_error();
    tick(); data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h7000; #1;
    checks++;
    if (data_gnt_o !== 1'b1) begin
      errors++; $display("FAIL err_gnt got %b exp 1", data_gnt_o);
    end
    tick(); data_req_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h800;
    HREADY = 1'b0; HRESP = 1'b1; #1;
    checks++;
    if ({HTRANS, instr_gnt_o, data_rvalid_o} !== {2'b00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL err_cycle1 got %b ig=%b drv=%b", HTRANS, instr_gnt_o, data_rvalid_o);
    end
    tick(); HREADY = 1'b1; #1;
    checks++;
    if ({data_rvalid_o, data_err_o, instr_rvalid_o} !== 3'b110) begin
      errors++; $display("FAIL err_cycle2 got rv=%b err=%b irv=%b", data_rvalid_o, data_err_o, instr_rvalid_o);
    end
    checks++;
    if ({instr_gnt_o, HTRANS, HADDR} !== {1'b1, 2'b10, 32'h800}) begin
      errors++; $display("FAIL err_rearb got %b %b %h", instr_gnt_o, HTRANS, HADDR);
    end
    tick(); instr_req_i = 1'b0; HRESP = 1'b0; #1;
    checks++;
    if ({instr_rvalid_o, instr_err_o, data_rvalid_o} !== 3'b100) begin
      errors++; $display("FAIL err_after got %b %b %b", instr_rvalid_o, instr_err_o, data_rvalid_o);
    end
  endtask

  task automatic test_be_map();
    for (int i = 0; i < 8; i++) begin
      tick();
      data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = be_tab[i]; data_addr_i = 32'h4000; #1;
      checks++;
      if (i == 7) begin
        if ({data_gnt_o, HTRANS} !== {1'b1, 2'b00}) begin
          errors++; $display("FAIL be_illegal got gnt=%b htrans=%b", data_gnt_o, HTRANS);
        end
      end else begin
        if ({data_gnt_o, HTRANS, HSIZE, HADDR} !== {1'b1, 2'b10, size_tab[i], 30'h1000, off_tab[i]}) begin
          errors++; $display("FAIL be_map[%0d] got %b %b %h %h", i, data_gnt_o, HTRANS, HSIZE, HADDR);
        end
      end
    end
    tick(); data_req_i = 1'b0; #1;
    checks++;
    if ({data_rvalid_o, data_err_o} !== 2'b11) begin
      errors++; $display("FAIL be_zero_err got %b%b exp 11", data_rvalid_o, data_err_o);
    end
  endtask

  task automatic test_illegal_and_reset();
    tick(); data_req_i = 1'b1; data_be_i = 4'b0101; data_addr_i = 32'h9000; #1;
    checks++;
    if ({data_gnt_o, HTRANS, data_rvalid_o} !== {1'b1, 2'b00, 1'b0}) begin
      errors++; $display("FAIL ill_gnt got %b %b %b", data_gnt_o, HTRANS, data_rvalid_o);
    end
    tick(); data_req_i = 1'b0; #1;
    checks++;
    if ({data_rvalid_o, data_err_o, HTRANS} !== {2'b11, 2'b00}) begin
      errors++; $display("FAIL ill_resp got %b %b %b", data_rvalid_o, data_err_o, HTRANS);
    end
    tick(); instr_req_i = 1'b1; instr_addr_i = 32'hA00; #1;
    checks++;
    if ({data_rvalid_o, instr_gnt_o} !== 2'b01) begin
      errors++; $display("FAIL ill_clear got drv=%b ig=%b", data_rvalid_o, instr_gnt_o);
    end
    tick(); instr_req_i = 1'b0; HREADY = 1'b0;
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF; data_addr_i = 32'hB000;
    data_wdata_i = 32'h1234_5678; #1;
    checks++;
    if ({data_gnt_o, HTRANS, HADDR} !== {1'b0, 2'b10, 32'hB000}) begin
      errors++; $display("FAIL rst_pre got %b %b %h", data_gnt_o, HTRANS, HADDR);
    end
    tick(); HRESET = 1'b1; #1;
    checks++;
    if ({HTRANS, data_gnt_o, instr_rvalid_o} !== {2'b00, 2'b00}) begin
      errors++; $display("FAIL rst_during got %b %b %b", HTRANS, data_gnt_o, instr_rvalid_o);
    end
    tick(); HRESET = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0; HREADY = 1'b1; #1;
    checks++;
    if ({instr_rvalid_o, data_rvalid_o, HTRANS, HADDR, HWDATA} !== {2'b00, 2'b00, 32'd0, 32'd0}) begin
      errors++; $display("FAIL rst_after got %b %b %b %h %h", instr_rvalid_o, data_rvalid_o, HTRANS, HADDR, HWDATA);
    end
    tick(); instr_req_i = 1'b1; instr_addr_i = 32'hC00; #1;
    checks++;
    if ({instr_gnt_o, HADDR} !== {1'b1, 32'hC00}) begin
      errors++; $display("FAIL rst_unlock got %b %h", instr_gnt_o, HADDR);
    end
    tick(); instr_req_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_instr_stream();
    test_fairness();
    test_store_wait();
    test_aph_lock();
    test_error();
    test_be_map();
    test_illegal_and_reset();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
